riscv_lsu_ma: RTL and testbench

RISCV_LSU_MA -- requirements
Module: riscv_lsu_ma

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/riscv_lsu_align.sv | 53 +++++
 rtl/riscv_lsu_ma.sv | 169 ++++++++++++++++
 tb/tb_riscv_lsu_ma.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared load/store definitions for the RISC-V LSU: access size codes,
// the LSU state encoding and the byte-mask lookup.
package riscv_pkg;

  // Access size codes (funct3 encoding); 3, 6 and 7 are illegal.
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  // Unshifted byte mask for a size code; zero marks an illegal code.
  function automatic logic [3:0] ldst_base_mask(input logic [2:0] size);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      LDST_B, LDST_BU: m = 4'b0001;
      LDST_H, LDST_HU: m = 4'b0011;
      LDST_W:          m = 4'b1111;
      default:         m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering for the LSU: byte enables and store data for
// both beats, load-data extraction/extension, and size/alignment decode.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [31:0] wd,
  input  logic [31:0] rd0,
  input  logic [31:0] rd1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wd0,
  output logic [31:0] wd1,
  output logic [31:0] rd,
  output logic        illegal,
  output logic        misaligned
);

  logic [3:0]  base;
  logic [7:0]  mask;
  logic [63:0] wide_wd;
  logic [31:0] shifted;

  // Mask, store-data shift and alignment classification.
  always_comb begin
    base       = ldst_base_mask(size);
    illegal    = (base == 4'b0000);
    mask       = {4'b0000, base} << off;
    be0        = mask[3:0];
    be1        = mask[7:4];
    wide_wd    = {32'h0, wd} << {off, 3'b000};
    wd0        = wide_wd[31:0];
    wd1        = wide_wd[63:32];
    misaligned = (((size == LDST_H) || (size == LDST_HU)) && (off == 2'd3)) ||
                 ((size == LDST_W) && (off != 2'd0));
  end

  // Load result: realign the two beats, then sign/zero-extend to 32 bits.
  always_comb begin
    shifted = 32'({rd1, rd0} >> {off, 3'b000});
    rd      = 32'h0;
    case (size)
      LDST_B:  rd = {{24{shifted[7]}}, shifted[7:0]};
      LDST_BU: rd = {24'h0, shifted[7:0]};
      LDST_H:  rd = {{16{shifted[15]}}, shifted[15:0]};
      LDST_HU: rd = {16'h0, shifted[15:0]};
      LDST_W:  rd = shifted;
      default: rd = 32'h0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu_ma.sv
// RISC-V load/store unit with misaligned-access support: splits an access
// that crosses a word boundary into two word beats on a single-beat memory
// handshake, with per-beat timeout and error reporting.
module riscv_lsu_ma
  import riscv_pkg::*;
#(
  parameter bit          MISALIGN_EN = 1'b1,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, rd0_q, rd0_d, rd1_q, rd1_d, tmo_q, tmo_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d, err_q, err_d, mis_q, mis_d;

  logic        idle, beat1, done, reject, issue, tmo_hit;
  logic [31:0] sel_addr, sel_wd, base_addr, tmo_inc;
  logic [2:0]  sel_size;
  logic        sel_we;
  logic [3:0]  a_be0, a_be1;
  logic [31:0] a_wd0, a_wd1, a_rd;
  logic        a_illegal, a_misaligned;

  // In IDLE beat0 goes out the same cycle, so steer from the live core inputs.
  always_comb begin
    idle      = (state_q == IDLE);
    beat1     = (state_q == BEAT1);
    done      = (state_q == DONE);
    sel_addr  = idle ? core_addr_i : addr_q;
    sel_size  = idle ? core_size_i : size_q;
    sel_wd    = idle ? core_wd_i : wd_q;
    sel_we    = idle ? core_we_i : we_q;
    base_addr = {sel_addr[31:2], 2'b00};
    reject    = a_illegal | (a_misaligned & ~MISALIGN_EN);
    issue     = (idle & core_req_i & ~reject) | (state_q == BEAT0) | beat1;
    tmo_inc   = tmo_q + 32'd1;
    tmo_hit   = (TIMEOUT != 0) && issue && !mem_ready_i && (tmo_inc >= TIMEOUT);
  end

  riscv_lsu_align u_align (
    .off        (sel_addr[1:0]),
    .size       (sel_size),
    .wd         (sel_wd),
    .rd0        (rd0_q),
    .rd1        (rd1_q),
    .be0        (a_be0),
    .be1        (a_be1),
    .wd0        (a_wd0),
    .wd1        (a_wd1),
    .rd         (a_rd),
    .illegal    (a_illegal),
    .misaligned (a_misaligned)
  );

  // Next-state: latch the request in IDLE, then advance on beat completion or timeout.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    wd_d    = wd_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    err_d   = err_q;
    mis_d   = mis_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (core_req_i) begin
          addr_d = core_addr_i;
          size_d = core_size_i;
          we_d   = core_we_i;
          wd_d   = core_wd_i;
          rd0_d  = 32'h0;
          rd1_d  = 32'h0;  // stays zero when beat1 is skipped
          err_d  = 1'b0;
          mis_d  = 1'b0;
          tmo_d  = 32'h0;
          if (reject) begin
            err_d   = 1'b1;
            mis_d   = ~a_illegal;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
    if (issue) begin
      if (mem_ready_i) begin
        tmo_d = 32'h0;
        if (beat1) begin
          rd1_d   = mem_rd_i;
          state_d = DONE;
        end else begin
          rd0_d   = mem_rd_i;
          state_d = (a_be1 != 4'b0000) ? BEAT1 : DONE;
        end
      end else if (tmo_hit) begin
        tmo_d   = 32'h0;
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        tmo_d   = tmo_inc;
        state_d = beat1 ? BEAT1 : BEAT0;
      end
    end
  end

  // State and access registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      size_q  <= 3'd0;
      we_q    <= 1'b0;
      wd_q    <= 32'h0;
      rd0_q   <= 32'h0;
      rd1_q   <= 32'h0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs; gating with rst_ni keeps every output low while in reset.
  always_comb begin
    mem_req_o       = rst_ni & issue;
    mem_we_o        = mem_req_o & sel_we;
    mem_be_o        = mem_req_o ? (beat1 ? a_be1 : a_be0) : 4'b0000;
    mem_addr_o      = mem_req_o ? (base_addr + (beat1 ? 32'd4 : 32'd0)) : 32'h0;
    mem_wd_o        = mem_req_o ? (beat1 ? a_wd1 : a_wd0) : 32'h0;
    core_stall_o    = rst_ni & core_req_i & ~done;
    core_err_o      = rst_ni & done & err_q;
    core_misalign_o = rst_ni & done & mis_q;
    core_rd_o       = (rst_ni && done && !err_q && !we_q) ? a_rd : 32'h0;
  end

endmodule

// File: tb/tb_riscv_lsu_ma.sv
// Directed self-checking bench for riscv_lsu_ma: one instance with splitting
// enabled, one with splitting disabled, both with a short beat timeout.
module tb_riscv_lsu_ma;
  import riscv_pkg::*;

  logic        clk, rst_n;
  logic        core_req, core_req_nm, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;

  logic [31:0] rd, mem_addr, mem_wd;
  logic        stall, err, mis, mem_req, mem_we;
  logic [3:0]  mem_be;

  logic [31:0] rd_n, mem_addr_n, mem_wd_n;
  logic        stall_n, err_n, mis_n, mem_req_n, mem_we_n;
  logic [3:0]  mem_be_n;

  // Tiny memory: two programmable words, anything else reads a marker.
  logic [31:0] a0, d0, a1, d1;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_lsu_ma #(.MISALIGN_EN(1'b1), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .core_req_i(core_req), .core_we_i(core_we),
    .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(rd), .core_stall_o(stall), .core_err_o(err), .core_misalign_o(mis),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  riscv_lsu_ma #(.MISALIGN_EN(1'b0), .TIMEOUT(4)) dut_nm (
    .clk_i(clk), .rst_ni(rst_n), .core_req_i(core_req_nm), .core_we_i(core_we),
    .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(rd_n), .core_stall_o(stall_n), .core_err_o(err_n),
    .core_misalign_o(mis_n), .mem_req_o(mem_req_n), .mem_we_o(mem_we_n),
    .mem_be_o(mem_be_n), .mem_addr_o(mem_addr_n), .mem_wd_o(mem_wd_n),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_rd = 32'hDEAD_BEEF;
    if (mem_addr == a0) mem_rd = d0;
    else if (mem_addr == a1) mem_rd = d1;
  end

  task automatic drive(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wd);
    core_we   = we;
    core_size = size;
    core_addr = addr;
    core_wd   = wd;
    core_req  = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    drive(1'b1, LDST_W, 32'h100, 32'h1234_5678);
    core_req_nm = 1'b1;
    #3;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_checks++; if ({mem_be, mem_addr, mem_wd, mem_we} !== 69'h0) begin n_fail++; $display("FAIL rst_mem_bus: be=%h addr=%h wd=%h we=%b want 0", mem_be, mem_addr, mem_wd, mem_we); end
    n_checks++; if ({rd, err, mis} !== 34'h0) begin n_fail++; $display("FAIL rst_core_out: rd=%h err=%b mis=%b want 0", rd, err, mis); end
    n_checks++; if ({stall_n, mem_req_n} !== 2'b00) begin n_fail++; $display("FAIL rst_nm_out: stall=%b req=%b want 0", stall_n, mem_req_n); end
    @(negedge clk);
    core_req = 1'b0;
    core_req_nm = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_lw_aligned;
    a0 = 32'h100; d0 = 32'h1234_5678; a1 = 32'h1; d1 = 32'h0;
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, LDST_W, 32'h100, 32'h0);
    #1;
    n_checks++; if ({mem_req, mem_we} !== 2'b10) begin n_fail++; $display("FAIL lw_req: req=%b we=%b want 1 0", mem_req, mem_we); end
    n_checks++; if (mem_be !== 4'b1111) begin n_fail++; $display("FAIL lw_be: got %b want 1111", mem_be); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", mem_addr); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_stall: got %b want 1", stall); end
    @(negedge clk); #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_done_stall: got %b want 0", stall); end
    n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL lw_rd: got %h want 12345678", rd); end
    n_checks++; if ({err, mem_req} !== 2'b00) begin n_fail++; $display("FAIL lw_done_flags: err=%b req=%b want 0 0", err, mem_req); end
    core_req = 1'b0;
  endtask

  task automatic test_sw_split;
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, LDST_W, 32'h103, 32'hAABB_CCDD);
    #1;
    n_checks++; if ({mem_req, mem_we, mem_be} !== 6'b11_1000) begin n_fail++; $display("FAIL sw_b0_ctl: req=%b we=%b be=%b want 1 1 1000", mem_req, mem_we, mem_be); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_b0_addr: got %h want 00000100", mem_addr); end
    n_checks++; if (mem_wd[31:24] !== 8'hDD) begin n_fail++; $display("FAIL sw_b0_wd: got %h want DD", mem_wd[31:24]); end
    @(negedge clk); #1;
    n_checks++; if ({mem_req, mem_we, mem_be} !== 6'b11_0111) begin n_fail++; $display("FAIL sw_b1_ctl: req=%b we=%b be=%b want 1 1 0111", mem_req, mem_we, mem_be); end
    n_checks++; if (mem_addr !== 32'h104) begin n_fail++; $display("FAIL sw_b1_addr: got %h want 00000104", mem_addr); end
    n_checks++; if (mem_wd[23:0] !== 24'hAABBCC) begin n_fail++; $display("FAIL sw_b1_wd: got %h want AABBCC", mem_wd[23:0]); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sw_b1_stall: got %b want 1", stall); end
    @(negedge clk); #1;
    n_checks++; if ({stall, err, mem_req} !== 3'b000) begin n_fail++; $display("FAIL sw_done: stall=%b err=%b req=%b want 000", stall, err, mem_req); end
    core_req = 1'b0;
  endtask

  task automatic test_lh_split;
    a0 = 32'h0; d0 = 32'h8011_2233; a1 = 32'h4; d1 = 32'h4455_66FF;
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, LDST_H, 32'h3, 32'h0);
    #1;
    n_checks++; if ({mem_be, mem_addr} !== {4'b1000, 32'h0}) begin n_fail++; $display("FAIL lh_b0: be=%b addr=%h want 1000 00000000", mem_be, mem_addr); end
    @(negedge clk); #1;
    n_checks++; if ({mem_be, mem_addr} !== {4'b0001, 32'h4}) begin n_fail++; $display("FAIL lh_b1: be=%b addr=%h want 0001 00000004", mem_be, mem_addr); end
    @(negedge clk); #1;
    n_checks++; if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lh_rd: got %h want FFFFFF80", rd); end
    core_req = 1'b0;
    @(negedge clk);
    drive(1'b0, LDST_HU, 32'h3, 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (rd !== 32'h0000_FF80) begin n_fail++; $display("FAIL lhu_rd: got %h want 0000FF80", rd); end
    core_req = 1'b0;
  endtask

  task automatic test_wrap_and_reject;
    a0 = 32'hFFFF_FFFC; d0 = 32'h1122_3344; a1 = 32'h0; d1 = 32'h5566_7788;
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, LDST_W, 32'hFFFF_FFFE, 32'h0);
    #1;
    n_checks++; if ({mem_be, mem_addr} !== {4'b1100, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL wrap_b0: be=%b addr=%h want 1100 FFFFFFFC", mem_be, mem_addr); end
    @(negedge clk); #1;
    n_checks++; if ({mem_be, mem_addr} !== {4'b0011, 32'h0}) begin n_fail++; $display("FAIL wrap_b1: be=%b addr=%h want 0011 00000000", mem_be, mem_addr); end
    @(negedge clk); #1;
    n_checks++; if (rd !== 32'h7788_1122) begin n_fail++; $display("FAIL wrap_rd: got %h want 77881122", rd); end
    core_req = 1'b0;
    // Same access on the instance that rejects misaligned requests.
    @(negedge clk);
    drive(1'b0, LDST_W, 32'hFFFF_FFFE, 32'h0);
    core_req = 1'b0;
    core_req_nm = 1'b1;
    #1;
    n_checks++; if ({mem_req_n, stall_n} !== 2'b01) begin n_fail++; $display("FAIL nm_idle: req=%b stall=%b want 0 1", mem_req_n, stall_n); end
    @(negedge clk); #1;
    n_checks++; if ({err_n, mis_n, stall_n, mem_req_n} !== 4'b1100) begin n_fail++; $display("FAIL nm_done: err=%b mis=%b stall=%b req=%b want 1100", err_n, mis_n, stall_n, mem_req_n); end
    core_req_nm = 1'b0;
  endtask

  task automatic test_illegal;
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 3'd6, 32'h100, 32'h0);
    #1;
    n_checks++; if ({mem_req, stall} !== 2'b01) begin n_fail++; $display("FAIL ill_idle: req=%b stall=%b want 0 1", mem_req, stall); end
    @(negedge clk); #1;
    n_checks++; if ({err, mis, stall} !== 3'b100) begin n_fail++; $display("FAIL ill_done: err=%b mis=%b stall=%b want 100", err, mis, stall); end
    core_req = 1'b0;
  endtask

  task automatic test_bytes;
    a0 = 32'h100; d0 = 32'h1234_F600; a1 = 32'h1; d1 = 32'h0;
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, LDST_B, 32'h101, 32'h0);
    #1;
    n_checks++; if (mem_be !== 4'b0010) begin n_fail++; $display("FAIL lb_be: got %b want 0010", mem_be); end
    @(negedge clk); #1;
    n_checks++; if (rd !== 32'hFFFF_FFF6) begin n_fail++; $display("FAIL lb_rd: got %h want FFFFFFF6", rd); end
    core_req = 1'b0;
    @(negedge clk);
    drive(1'b0, LDST_BU, 32'h101, 32'h0);
    @(negedge clk); #1;
    n_checks++; if (rd !== 32'h0000_00F6) begin n_fail++; $display("FAIL lbu_rd: got %h want 000000F6", rd); end
    core_req = 1'b0;
    @(negedge clk);
    drive(1'b1, LDST_B, 32'h102, 32'h0000_00AB);
    #1;
    n_checks++; if ({mem_be, mem_wd} !== {4'b0100, 32'h00AB_0000}) begin n_fail++; $display("FAIL sb_lane: be=%b wd=%h want 0100 00AB0000", mem_be, mem_wd); end
    @(negedge clk);
    core_req = 1'b0;
  endtask

  task automatic test_timeout;
    mem_ready = 1'b0;
    @(negedge clk);
    drive(1'b0, LDST_W, 32'h200, 32'h0);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({mem_req, stall} !== 2'b11) begin n_fail++; $display("FAIL tmo_wait%0d: req=%b stall=%b want 1 1", i, mem_req, stall); end
      @(negedge clk); #1;
    end
    n_checks++; if ({mem_req, err, stall} !== 3'b010) begin n_fail++; $display("FAIL tmo_done: req=%b err=%b stall=%b want 0 1 0", mem_req, err, stall); end
    core_req = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, LDST_W, 32'h103, 32'hAABB_CCDD);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h104}) begin n_fail++; $display("FAIL rm_beat1: req=%b addr=%h want 1 00000104", mem_req, mem_addr); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({mem_req, mem_be, stall} !== 6'b0) begin n_fail++; $display("FAIL rm_in_reset: req=%b be=%b stall=%b want 0", mem_req, mem_be, stall); end
    core_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = 32'h100; d0 = 32'hCAFE_F00D; a1 = 32'h1; d1 = 32'h0;
    mem_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, LDST_W, 32'h100, 32'h0);
    #1;
    n_checks++; if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'b1111, 32'h100}) begin n_fail++; $display("FAIL rm_new_req: req=%b be=%b addr=%h want 1 1111 00000100", mem_req, mem_be, mem_addr); end
    @(negedge clk); #1;
    n_checks++; if ({rd, err, stall} !== {32'hCAFE_F00D, 2'b00}) begin n_fail++; $display("FAIL rm_new_done: rd=%h err=%b stall=%b want CAFEF00D 0 0", rd, err, stall); end
    core_req = 1'b0;
  endtask

  initial begin
    core_req = 1'b0; core_req_nm = 1'b0; core_we = 1'b0; core_size = LDST_W;
    core_addr = 32'h0; core_wd = 32'h0; mem_ready = 1'b0;
    a0 = 32'h1; d0 = 32'h0; a1 = 32'h1; d1 = 32'h0;
    test_reset;
    test_lw_aligned;
    test_sw_split;
    test_lh_split;
    test_wrap_and_reject;
    test_illegal;
    test_bytes;
    test_timeout;
    test_reset_mid;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
